edge_event_arbiter: RTL and testbench
=====================================

Name: edge_event_arbiter

Overview:
- Multi-channel edge-event scheduler. Synchronises NUM_CH asynchronous inputs and detects rising/falling edges per channel.
- Latches detected edges as pending events.
- Serialises pending events to one consumer over a valid/ready port, using round-robin arbitration across channels.
- Sits between raw level inputs (buttons, status lines) and a single event-handling engine.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- CH_W, $clog2(NUM_CH), derived localparam, width of the channel index.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sig_in  in  NUM_CH  asynchronous level inputs.
- rise_en  in  NUM_CH  per-channel rising-edge event enable.
- fall_en  in  NUM_CH  per-channel falling-edge event enable.
- evt_valid  out  1  event available on evt_ch/evt_is_rise.
- evt_ready  in  1  consumer accepts event when high with evt_valid.
- evt_ch  out  CH_W  channel index of the presented event.
- evt_is_rise  out  1  1 = rising edge, 0 = falling edge.
- overflow  out  NUM_CH  sticky per-channel lost-event flag.
- clr_overflow  in  NUM_CH  per-channel synchronous clear of overflow.

Behaviour:
- Reset values (reset_n low, asynchronous):
  - All sync flops and prev-level flops = 0.
  - Pending bits = 0; round-robin pointer = 0.
  - evt_valid = 0, evt_ch = 0, evt_is_rise = 0, overflow = 0.
- Edge detection per channel, on the synchroniser output s and its one-cycle-delayed copy p:
  - rise = s & ~p
  - fall = ~s & p
- Input already high at reset release: produces a rising event (p resets to 0).
- Pending: two bits per channel, pend_r and pend_f.
  - pend_r sets on rise & rise_en; pend_f sets on fall & fall_en.
  - Disabled edges are dropped and do not set overflow.
- Overflow: an edge arriving while its same-type pending bit is already set and not cleared this cycle.
  - Sets overflow[ch]; the event is merged (no second event).
  - clr_overflow[ch] clears overflow[ch] unless a new overflow occurs in the same cycle; set wins.
- Output slot: registered, one entry.
  - Load condition: slot empty (!evt_valid) or accepted this cycle (evt_valid & evt_ready).
  - Selection:
    - Search channels starting at pointer, ascending, wrapping NUM_CH-1 -> 0.
    - Pick the first channel with any pending bit.
    - Within that channel, pend_r is served before pend_f.
  - On load: chosen pending bit is cleared, evt_valid = 1, fields loaded, pointer = chosen channel + 1 (mod NUM_CH).
  - A channel with both bits pending yields its fall event only after the other channels have had a turn.
  - Nothing pending when the load condition holds: evt_valid = 0 next cycle.
- Simultaneous clear and set of the same pending bit: the new edge wins. The bit stays set and no overflow is flagged.
- Handshake rules:
  - evt_valid, once high, stays high with evt_ch/evt_is_rise stable until evt_ready.
  - evt_valid never depends combinationally on evt_ready.
  - Back-to-back events are accepted every cycle with evt_ready held high.
- Latency: from the clk edge that first samples a new sig_in level to evt_valid high is SYNC_STAGES+1 cycles, with the slot idle and no competing events.
- Reset mid-operation: pending events, the presented event and overflow flags are discarded immediately.

Optional Feature:
- Macro: EDGE_ARB_TIMESTAMP_EN.
- Defined:
  - Adds parameter TS_W (default 16) and output evt_ts [TS_W].
  - A free-running counter (reset 0, wraps at 2^TS_W) is captured per pending bit when it sets; on merge the original timestamp is kept.
  - evt_ts is presented with the event and obeys the same stability rules.
- Undefined: no counter, no timestamp storage, no evt_ts port.

Decomposition:
- Package edge_arb_pkg: evt_type_e enum (EVT_FALL=0, EVT_RISE=1), default TS_W constant, and a function for round-robin next-index search.
- Sub-module edge_sync_detect: one channel, containing the SYNC_STAGES synchroniser plus prev flop; outputs rise/fall pulses. Instantiated NUM_CH times in a generate loop.

Test Plan:
- Reset and idle:
  - Hold reset_n=0 with sig_in=4'b0000, then release -> evt_valid=0 and overflow=0 indefinitely.
  - Assert reset_n=0 while evt_valid=1 -> outputs return to 0 asynchronously.
- Single rise:
  - rise_en=4'hF, evt_ready=1, sig_in[2] 0->1 -> evt_valid high exactly 3 cycles later (SYNC_STAGES=2) for one cycle, evt_ch=2, evt_is_rise=1.
  - sig_in[2] 1->0 with fall_en[2]=0 -> no event.
- Round-robin:
  - evt_ready=0; rise on channels 0, 1 and 3 in the same cycle; then evt_ready=1 -> events in order ch0, ch1, ch3, one per cycle.
  - Next rise on channels 0 and 3 together -> ch0 issued first (pointer=0 after wrap from ch3).
- Backpressure:
  - evt_ready=0 for 10 cycles with one event presented -> evt_ch/evt_is_rise stable and evt_valid held.
  - Raise evt_ready -> accepted once, no duplicate.
- Overflow:
  - evt_ready=0; sig_in[1] toggles 0->1->0->1 (enable both edges) -> overflow[1]=1.
  - On draining -> exactly one rise event then one fall event for ch1.
  - clr_overflow[1] pulse -> overflow[1]=0.
- Timestamp (EDGE_ARB_TIMESTAMP_EN):
  - Counter at 100 when a ch0 rise detects; evt_ready held 0 for 50 cycles -> evt_ts=100 on acceptance.

Source files
------------

// File: rtl/edge_event_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// edge_arb_pkg
// Shared types and helpers for the edge_event_arbiter block.
//   evt_type_e    : event polarity carried with every presented event
//   TS_W_DEFAULT  : default timestamp width used when EDGE_ARB_TIMESTAMP_EN is set
//   MAX_CH        : largest supported channel count
//   rr_pick()     : round-robin search over a request vector
// -----------------------------------------------------------------------------
package edge_arb_pkg;

  typedef enum logic {
    EVT_FALL = 1'b0,
    EVT_RISE = 1'b1
  } evt_type_e;

  localparam int TS_W_DEFAULT = 16;
  localparam int MAX_CH       = 16;

  // Returns {found, index}. The search starts at ptr, ascends, and wraps from
  // num_ch-1 back to 0. Requests above num_ch-1 are ignored.
  function automatic logic [4:0] rr_pick(input logic [MAX_CH-1:0] req,
                                         input logic [3:0]        ptr,
                                         input int                num_ch);
    logic [4:0] res;
    int         idx;
    res = '0;
    for (int k = 0; k < MAX_CH; k++) begin
      if (k < num_ch) begin
        idx = 32'(ptr) + k;
        if (idx >= num_ch) idx = idx - num_ch;
        if (!res[4] && req[idx[3:0]]) res = {1'b1, idx[3:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/edge_event_arbiter_sync_detect.sv
// -----------------------------------------------------------------------------
// edge_sync_detect
// One channel of input conditioning: a SYNC_STAGES-deep synchroniser followed
// by a previous-level flop, producing single-cycle rise/fall pulses.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset (all flops cleared)
//   i_sig    in  asynchronous level input
//   o_rise   out synchronised level went 0 -> 1
//   o_fall   out synchronised level went 1 -> 0
// The previous-level flop resets to 0, so an input already high when reset
// releases is reported as a rising edge.
// -----------------------------------------------------------------------------
module edge_sync_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_prev <= w_s;
    end
  end

  assign o_rise = w_s & ~r_prev;
  assign o_fall = ~w_s & r_prev;

endmodule

// File: rtl/edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter
// Multi-channel edge-event scheduler. Each level input is synchronised and
// edge-detected, detected edges are latched as pending rise/fall bits, and
// pending events are served round-robin to a single consumer through a
// one-entry registered valid/ready slot.
// Optional feature macro: EDGE_ARB_TIMESTAMP_EN (adds TS_W and evt_ts).
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   sig_in        in   [NUM_CH]  asynchronous level inputs
//   rise_en       in   [NUM_CH]  per-channel rising-edge enable
//   fall_en       in   [NUM_CH]  per-channel falling-edge enable
//   evt_valid     out  event present on evt_ch / evt_is_rise
//   evt_ready     in   consumer accepts when high with evt_valid
//   evt_ch        out  [CH_W]    channel of the presented event
//   evt_is_rise   out  1 = rising edge, 0 = falling edge
//   overflow      out  [NUM_CH]  sticky lost-event flags
//   clr_overflow  in   [NUM_CH]  synchronous clear of overflow (set wins)
//   evt_ts        out  [TS_W]    capture time of the event (macro only)
// -----------------------------------------------------------------------------
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int SYNC_STAGES = 2,
`ifdef EDGE_ARB_TIMESTAMP_EN
  parameter  int TS_W        = TS_W_DEFAULT,
`endif
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] sig_in,
  input  logic [NUM_CH-1:0] rise_en,
  input  logic [NUM_CH-1:0] fall_en,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_is_rise,
  output logic [NUM_CH-1:0] overflow,
  input  logic [NUM_CH-1:0] clr_overflow
`ifdef EDGE_ARB_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]   evt_ts
`endif
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic [NUM_CH-1:0] w_rise, w_fall;
  logic [NUM_CH-1:0] w_set_r, w_set_f;
  logic [NUM_CH-1:0] w_clr_r, w_clr_f;
  logic [NUM_CH-1:0] w_keep_r, w_keep_f;
  logic [NUM_CH-1:0] w_ovf_r, w_ovf_f;
  logic [4:0]        w_pick;
  logic              w_found;
  logic [CH_W-1:0]   w_idx;
  logic              w_load;

  logic [NUM_CH-1:0] r_pend_r, r_pend_f;
  logic [NUM_CH-1:0] r_ovf;
  logic [CH_W-1:0]   r_ptr;
  logic              r_valid;
  logic [CH_W-1:0]   r_ch;
  evt_type_e         r_type;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    edge_sync_detect #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_sig   (sig_in[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g])
    );
  end

  // Slot refills when empty or when its current event is accepted this cycle;
  // evt_ready only affects the next state, never evt_valid directly.
  assign w_load  = !r_valid || evt_ready;

  assign w_pick  = rr_pick(MAX_CH'(r_pend_r | r_pend_f), 4'(r_ptr), NUM_CH);
  assign w_found = w_pick[4];
  assign w_idx   = CH_W'(w_pick[3:0]);

  // Rise is served before fall within the chosen channel.
  always_comb begin
    w_clr_r = '0;
    w_clr_f = '0;
    if (w_load && w_found) begin
      if (r_pend_r[w_idx]) w_clr_r[w_idx] = 1'b1;
      else                 w_clr_f[w_idx] = 1'b1;
    end
  end

  assign w_set_r  = w_rise & rise_en;
  assign w_set_f  = w_fall & fall_en;
  // A pending bit that survives this cycle turns a new same-type edge into a
  // merge; a bit being served this cycle simply re-arms without overflow.
  assign w_keep_r = r_pend_r & ~w_clr_r;
  assign w_keep_f = r_pend_f & ~w_clr_f;
  assign w_ovf_r  = w_set_r & w_keep_r;
  assign w_ovf_f  = w_set_f & w_keep_f;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_r <= '0;
      r_pend_f <= '0;
      r_ovf    <= '0;
      r_ptr    <= '0;
      r_valid  <= 1'b0;
      r_ch     <= '0;
      r_type   <= EVT_FALL;
    end else begin
      r_pend_r <= w_keep_r | w_set_r;
      r_pend_f <= w_keep_f | w_set_f;
      r_ovf    <= (r_ovf & ~clr_overflow) | w_ovf_r | w_ovf_f;
      if (w_load) begin
        if (w_found) begin
          r_valid <= 1'b1;
          r_ch    <= w_idx;
          r_type  <= r_pend_r[w_idx] ? EVT_RISE : EVT_FALL;
          r_ptr   <= (w_idx == LAST_CH) ? '0 : w_idx + CH_W'(1);
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign evt_valid   = r_valid;
  assign evt_ch      = r_ch;
  assign evt_is_rise = r_type;
  assign overflow    = r_ovf;

`ifdef EDGE_ARB_TIMESTAMP_EN
  logic [TS_W-1:0] r_cnt;
  logic [TS_W-1:0] r_ts_out;
  logic [TS_W-1:0] r_ts_r [NUM_CH];
  logic [TS_W-1:0] r_ts_f [NUM_CH];

  // A timestamp is captured only when its pending bit goes from empty to set,
  // so a merged edge keeps the original time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_ts_out <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_ts_r[c] <= '0;
        r_ts_f[c] <= '0;
      end
    end else begin
      r_cnt <= r_cnt + TS_W'(1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_set_r[c] && !w_keep_r[c]) r_ts_r[c] <= r_cnt;
        if (w_set_f[c] && !w_keep_f[c]) r_ts_f[c] <= r_cnt;
      end
      if (w_load && w_found)
        r_ts_out <= r_pend_r[w_idx] ? r_ts_r[w_idx] : r_ts_f[w_idx];
    end
  end

  assign evt_ts = r_ts_out;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
`timescale 1ns/1ps
module tb_edge_event_arbiter;

  localparam int N = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] sig_in = '0;
  logic [N-1:0] rise_en = '0;
  logic [N-1:0] fall_en = '0;
  logic [N-1:0] clr_overflow = '0;
  logic         evt_ready = 1'b0;
  logic         evt_valid;
  logic [1:0]   evt_ch;
  logic         evt_is_rise;
  logic [N-1:0] overflow;
`ifdef EDGE_ARB_TIMESTAMP_EN
  logic [15:0]  evt_ts;
  logic [15:0]  last_ts = '0;
`endif

  edge_event_arbiter #(
    .NUM_CH      (N),
    .SYNC_STAGES (S)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sig_in       (sig_in),
    .rise_en      (rise_en),
    .fall_en      (fall_en),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_ch       (evt_ch),
    .evt_is_rise  (evt_is_rise),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef EDGE_ARB_TIMESTAMP_EN
    ,
    .evt_ts       (evt_ts)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]  ch;
    logic        rise;
`ifdef EDGE_ARB_TIMESTAMP_EN
    logic [15:0] ts;
`endif
  } ev_t;

  ev_t          exp_q[$];
  logic [2:0]   acc_log[$];
  logic [N-1:0] hist[$];      // hist[0] = most recently sampled sig_in
  logic [N-1:0] m_pr, m_pf, m_ovf;
  int           m_ptr;
  logic         m_v;
`ifdef EDGE_ARB_TIMESTAMP_EN
  logic [15:0]  m_cnt;
  logic [15:0]  m_tr [N];
  logic [15:0]  m_tf [N];
`endif

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= S; i++) hist.push_back('0);
    m_pr = '0; m_pf = '0; m_ovf = '0; m_ptr = 0; m_v = 1'b0;
    exp_q.delete();
`ifdef EDGE_ARB_TIMESTAMP_EN
    m_cnt = '0;
`endif
  endtask

  task automatic model_step();
    logic [N-1:0] s, p, rv, fv;
    ev_t          ev;
    int           c;
    s  = hist[S-1];
    p  = hist[S];
    rv = s & ~p & rise_en;
    fv = ~s & p & fall_en;
    if (!m_v || evt_ready) begin
      m_v = 1'b0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!m_v && (m_pr[c] || m_pf[c])) begin
          ev.ch   = 2'(c);
          ev.rise = m_pr[c];
`ifdef EDGE_ARB_TIMESTAMP_EN
          ev.ts   = m_pr[c] ? m_tr[c] : m_tf[c];
`endif
          if (m_pr[c]) m_pr[c] = 1'b0;
          else         m_pf[c] = 1'b0;
          m_ptr = (c + 1) % N;
          m_v   = 1'b1;
          exp_q.push_back(ev);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (clr_overflow[i]) m_ovf[i] = 1'b0;
      if (rv[i]) begin
        if (m_pr[i]) m_ovf[i] = 1'b1;
        else begin
          m_pr[i] = 1'b1;
`ifdef EDGE_ARB_TIMESTAMP_EN
          m_tr[i] = m_cnt;
`endif
        end
      end
      if (fv[i]) begin
        if (m_pf[i]) m_ovf[i] = 1'b1;
        else begin
          m_pf[i] = 1'b1;
`ifdef EDGE_ARB_TIMESTAMP_EN
          m_tf[i] = m_cnt;
`endif
        end
      end
    end
`ifdef EDGE_ARB_TIMESTAMP_EN
    m_cnt = m_cnt + 16'd1;
`endif
    hist.push_front(sig_in);
    void'(hist.pop_back());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("evt_valid", 32'(evt_valid), 32'(m_v));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (evt_valid && evt_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_event: got ch %0d rise %0d, expected no event", evt_ch, evt_is_rise);
          end else begin
            ev = exp_q.pop_front();
            chk("evt_ch", 32'(evt_ch), 32'(ev.ch));
            chk("evt_is_rise", 32'(evt_is_rise), 32'(ev.rise));
`ifdef EDGE_ARB_TIMESTAMP_EN
            chk("evt_ts", 32'(evt_ts), 32'(ev.ts));
            last_ts = evt_ts;
`endif
          end
          acc_log.push_back({evt_ch, evt_is_rise});
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset and idle
    cyc(3);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_ch", 32'(evt_ch), 32'd0);
    chk("rst_rise", 32'(evt_is_rise), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    cyc(20);
    chk("idle_valid", 32'(evt_valid), 32'd0);

    // Single rise: exact latency SYNC_STAGES+1 from the sampling edge
    rise_en = 4'hF; fall_en = 4'h0; evt_ready = 1'b1;
    sig_in[2] = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk("lat_valid", 32'(evt_valid), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("lat_ch", 32'(evt_ch), 32'd2);
    chk("lat_rise", 32'(evt_is_rise), 32'd1);
    cyc(1);
    chk("lat_single", 32'(evt_valid), 32'd0);
    sig_in[2] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("no_fall_evt", 32'(evt_valid), 32'd0);
    end

    // Round-robin ordering from pointer 0
    do_reset();
    evt_ready = 1'b0;
    sig_in = 4'b1011;
    cyc(8);
    acc_log.delete();
    evt_ready = 1'b1;
    cyc(6);
    chk("rr_count", 32'(acc_log.size()), 32'd3);
    if (acc_log.size() >= 3) begin
      chk("rr_first", 32'(acc_log[0]), 32'd1);
      chk("rr_second", 32'(acc_log[1]), 32'd3);
      chk("rr_third", 32'(acc_log[2]), 32'd7);
    end
    sig_in = 4'b0010;
    cyc(6);
    acc_log.delete();
    sig_in = 4'b1011;
    cyc(8);
    chk("rr_wrap_count", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() >= 2) begin
      chk("rr_wrap_first", 32'(acc_log[0]), 32'd1);
      chk("rr_wrap_second", 32'(acc_log[1]), 32'd7);
    end

    // Backpressure: held event stays stable, accepted once
    evt_ready = 1'b0; fall_en = 4'hF;
    sig_in[1] = 1'b0;
    cyc(5);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(evt_valid), 32'd1);
      chk("bp_ch", 32'(evt_ch), 32'd1);
      chk("bp_rise", 32'(evt_is_rise), 32'd0);
      cyc(1);
    end
    acc_log.delete();
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    cyc(3);
    chk("bp_once", 32'(acc_log.size()), 32'd1);
    chk("bp_drained", 32'(evt_valid), 32'd0);

    // Overflow on channel 1 while the slot is occupied by channel 0
    sig_in[0] = 1'b0;
    cyc(5);
    sig_in[1] = 1'b1; cyc(4);
    sig_in[1] = 1'b0; cyc(4);
    sig_in[1] = 1'b1; cyc(4);
    chk("ovf_set", 32'(overflow[1]), 32'd1);
    acc_log.delete();
    evt_ready = 1'b1;
    cyc(6);
    evt_ready = 1'b0;
    chk("ovf_drain_count", 32'(acc_log.size()), 32'd3);
    if (acc_log.size() >= 3) begin
      chk("ovf_drain0", 32'(acc_log[0]), 32'd0);
      chk("ovf_drain1", 32'(acc_log[1]), 32'd3);
      chk("ovf_drain2", 32'(acc_log[2]), 32'd2);
    end
    chk("ovf_sticky", 32'(overflow[1]), 32'd1);
    clr_overflow[1] = 1'b1;
    cyc(1);
    clr_overflow = '0;
    chk("ovf_cleared", 32'(overflow[1]), 32'd0);

    // Asynchronous reset while an event is presented
    sig_in[2] = 1'b1;
    cyc(5);
    chk("pre_rst_valid", 32'(evt_valid), 32'd1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(evt_valid), 32'd0);
    chk("async_rst_ch", 32'(evt_ch), 32'd0);
    chk("async_rst_rise", 32'(evt_is_rise), 32'd0);
    cyc(2);
    reset_n = 1'b1;

    // Randomised traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        rise_en = 4'($urandom);
        fall_en = 4'($urandom);
      end
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) sig_in[b] = ~sig_in[b];
      evt_ready    = (i % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      clr_overflow = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      if (i == 1700) begin
        @(posedge clk); #2;
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
      end else begin
        cyc(1);
      end
    end
    clr_overflow = '0;

`ifdef EDGE_ARB_TIMESTAMP_EN
    // Timestamp held through long backpressure
    evt_ready = 1'b0; rise_en = 4'hF; fall_en = 4'h0; sig_in = '0;
    do_reset();
    repeat (98) @(posedge clk);
    #1;
    sig_in[0] = 1'b1;
    cyc(53);
    acc_log.delete();
    evt_ready = 1'b1;
    cyc(2);
    chk("ts_accept", 32'(acc_log.size()), 32'd1);
    chk("ts_value", 32'(last_ts), 32'd100);
`endif

    evt_ready = 1'b1;
    cyc(10);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
